// File: rtl/alu_arbiter.sv
// Two-port arbiter that shares one LC-3 ALU: latches the winning request,
// drives the ALU inputs, captures the result and maintains the NZP register.
module alu_arbiter #(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             req0,
  input  logic [1:0]       aluk0,
  input  logic [WIDTH-1:0] opa0,
  input  logic [WIDTH-1:0] opb0,
  input  logic             ldcc0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic [1:0]       aluk1,
  input  logic [WIDTH-1:0] opa1,
  input  logic [WIDTH-1:0] opb1,
  input  logic             ldcc1,
  output logic             gnt1,
  output logic             done1,
  output logic [1:0]       alu_aluk,
  output logic [WIDTH-1:0] alu_sr1,
  output logic [WIDTH-1:0] alu_sr2,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  logic   last;      // port granted most recently; resets to 1 so port 0 wins first tie
  logic   sel_port;
  logic   sel_ldcc;
  logic   win;
  logic   any_req;

  assign any_req = req0 | req1;

  always_comb begin
    win = 1'b0;
    if (req0 && req1)
      win = (RR_EN != 0) ? ~last : 1'b0;
    else if (req1)
      win = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      sel_port <= 1'b0;
      sel_ldcc <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      alu_aluk <= '0;
      alu_sr1  <= '0;
      alu_sr2  <= '0;
      result   <= '0;
      cc       <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        EXEC: begin
          result <= alu_result;
          if (sel_ldcc) begin
            if (alu_result[WIDTH-1])
              cc <= 3'b100;
            else if (alu_result == '0)
              cc <= 3'b010;
            else
              cc <= 3'b001;
          end
          done0 <= ~sel_port;
          done1 <= sel_port;
          busy  <= 1'b1;
          state <= DONE;
        end
        default: begin
          // IDLE and DONE both arbitrate, so a pending request skips IDLE
          if (any_req) begin
            if (win) begin
              alu_aluk <= aluk1;
              alu_sr1  <= opa1;
              alu_sr2  <= opb1;
              sel_ldcc <= ldcc1;
            end else begin
              alu_aluk <= aluk0;
              alu_sr1  <= opa0;
              alu_sr2  <= opb0;
              sel_ldcc <= ldcc0;
            end
            sel_port <= win;
            last     <= win;
            gnt0     <= ~win;
            gnt1     <= win;
            busy     <= 1'b1;
            state    <= EXEC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin and fixed-priority instances
// share one set of requester inputs, each driving its own ALU model.
module tb_alu_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  aluk0 = '0, aluk1 = '0;
  logic [15:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
  logic        ldcc0 = 1'b0, ldcc1 = 1'b0;

  logic        gnt0_r, gnt1_r, done0_r, done1_r, busy_r;
  logic [1:0]  aluk_r;
  logic [15:0] sr1_r, sr2_r, ares_r, result_r;
  logic [2:0]  cc_r;

  logic        gnt0_f, gnt1_f, done0_f, done1_f, busy_f;
  logic [1:0]  aluk_f;
  logic [15:0] sr1_f, sr2_f, ares_f, result_f;
  logic [2:0]  cc_f;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  function automatic logic [15:0] alu(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
    case (k)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return ~a;
      default: return a;
    endcase
  endfunction

  assign ares_r = alu(aluk_r, sr1_r, sr2_r);
  assign ares_f = alu(aluk_f, sr1_f, sr2_f);

  alu_arbiter #(.RR_EN(1), .WIDTH(16)) dut_rr (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(req0), .aluk0(aluk0), .opa0(opa0), .opb0(opb0), .ldcc0(ldcc0),
    .gnt0(gnt0_r), .done0(done0_r),
    .req1(req1), .aluk1(aluk1), .opa1(opa1), .opb1(opb1), .ldcc1(ldcc1),
    .gnt1(gnt1_r), .done1(done1_r),
    .alu_aluk(aluk_r), .alu_sr1(sr1_r), .alu_sr2(sr2_r), .alu_result(ares_r),
    .result(result_r), .cc(cc_r), .busy(busy_r)
  );

  alu_arbiter #(.RR_EN(0), .WIDTH(16)) dut_fp (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(req0), .aluk0(aluk0), .opa0(opa0), .opb0(opb0), .ldcc0(ldcc0),
    .gnt0(gnt0_f), .done0(done0_f),
    .req1(req1), .aluk1(aluk1), .opa1(opa1), .opb1(opb1), .ldcc1(ldcc1),
    .gnt1(gnt1_f), .done1(done1_f),
    .alu_aluk(aluk_f), .alu_sr1(sr1_f), .alu_sr2(sr2_f), .alu_result(ares_f),
    .result(result_f), .cc(cc_f), .busy(busy_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One isolated operation from port p; both instances must behave alike.
  task automatic run_op(input int p, input logic [1:0] k, input logic [15:0] a,
                        input logic [15:0] b, input logic l,
                        input logic [15:0] er, input logic [2:0] ec);
    logic [1:0] pv;
    pv = (p == 0) ? 2'b01 : 2'b10;
    if (p == 0) begin
      req0 = 1'b1; aluk0 = k; opa0 = a; opb0 = b; ldcc0 = l;
    end else begin
      req1 = 1'b1; aluk1 = k; opa1 = a; opb1 = b; ldcc1 = l;
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    opa0 = 16'hDEAD; opa1 = 16'hBEEF; opb0 = 16'h5A5A; opb1 = 16'hA5A5;
    check("gnt_rr", {gnt1_r, gnt0_r}, pv);
    check("gnt_fp", {gnt1_f, gnt0_f}, pv);
    check("done_exec", {done1_r, done0_r}, 2'b00);
    check("alu_in", {aluk_r, sr1_r, sr2_r}, {k, a, b});
    check("busy_exec", busy_r, 1'b1);
    step();
    check("done_rr", {done1_r, done0_r}, pv);
    check("done_fp", {done1_f, done0_f}, pv);
    check("gnt_after", {gnt1_r, gnt0_r}, 2'b00);
    check("result_rr", result_r, er);
    check("result_fp", result_f, er);
    check("cc_rr", cc_r, ec);
    check("cc_fp", cc_f, ec);
    step();
    check("idle_busy", {busy_r, done1_r, done0_r}, 3'b000);
    check("hold_alu_in", {sr1_r, sr2_r}, {a, b});
    check("hold_result", result_r, er);
  endtask

  typedef struct {
    int          port;
    logic [1:0]  k;
    logic [15:0] a;
    logic [15:0] b;
    logic        l;
    logic [15:0] er;
    logic [2:0]  ec;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // cc column carries over wherever ldcc is 0
    vecs[0] = '{0, 2'b00, 16'h0003, 16'h0004, 1'b1, 16'h0007, 3'b001};
    vecs[1] = '{1, 2'b10, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 3'b100};
    vecs[2] = '{0, 2'b11, 16'h1234, 16'h0000, 1'b0, 16'h1234, 3'b100};
    vecs[3] = '{1, 2'b00, 16'h8000, 16'h8000, 1'b1, 16'h0000, 3'b010};
    vecs[4] = '{0, 2'b01, 16'hFFFF, 16'h00F0, 1'b1, 16'h00F0, 3'b001};
    vecs[5] = '{1, 2'b00, 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 3'b001};
    vecs[6] = '{0, 2'b11, 16'h8001, 16'h0000, 1'b1, 16'h8001, 3'b100};

    repeat (3) step();
    check("rst_outs", {gnt0_r, gnt1_r, done0_r, done1_r, busy_r}, 5'b0);
    check("rst_alu", {aluk_r, sr1_r, sr2_r}, 34'h0);
    check("rst_res_cc", {result_r, cc_r}, 19'h0);
    Reset_n = 1'b1;
    step();
    check("idle_no_req", busy_r, 1'b0);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].port, vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].er, vecs[i].ec);

    // Both requests held from reset: RR alternates, fixed priority stays on port 0
    Reset_n = 1'b0;
    aluk0 = 2'b00; opa0 = 16'h0001; opb0 = 16'h0001; ldcc0 = 1'b0;
    aluk1 = 2'b11; opa1 = 16'h0005; opb1 = 16'h0000; ldcc1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_gnt", {gnt1_r, gnt0_r}, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("fp_gnt", {gnt1_f, gnt0_f}, 2'b01);
      check("rr_busy_exec", busy_r, 1'b1);
      step();
      check("rr_done", {done1_r, done0_r}, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_result", result_r, (i % 2 == 0) ? 16'h0002 : 16'h0005);
      check("fp_done", {done1_f, done0_f}, 2'b01);
      check("rr_busy_done", busy_r, 1'b1);
    end
    req0 = 1'b0;
    step();
    check("fp_gnt_p1", {gnt1_f, gnt0_f}, 2'b10);
    req1 = 1'b0;
    step();
    check("fp_done_p1", {done1_f, done0_f}, 2'b10);
    check("fp_result_p1", result_f, 16'h0005);
    step();

    // Reset during EXEC after a port-0 grant: abort, then port 0 wins the next tie
    req0 = 1'b1; aluk0 = 2'b00; opa0 = 16'h0003; opb0 = 16'h0004; ldcc0 = 1'b1;
    step();
    req0 = 1'b0;
    check("pre_rst_gnt", gnt0_r, 1'b1);
    step();
    check("pre_rst_cc", cc_r, 3'b001);
    req0 = 1'b1; aluk0 = 2'b11; opa0 = 16'h0009;
    step();
    req0 = 1'b0;
    check("pre_rst_exec", gnt0_r, 1'b1);
    Reset_n = 1'b0;
    #1;
    check("abort_outs", {gnt0_r, gnt1_r, done0_r, done1_r, busy_r}, 5'b0);
    check("abort_res_cc", {result_r, cc_r}, 19'h0);
    check("abort_alu", sr1_r, 16'h0000);
    Reset_n = 1'b1;
    step();
    check("abort_no_done", {done1_r, done0_r, busy_r}, 3'b000);
    req0 = 1'b1; req1 = 1'b1; opa0 = 16'h0011; opa1 = 16'h0022;
    aluk0 = 2'b11; aluk1 = 2'b11;
    step();
    req0 = 1'b0; req1 = 1'b0;
    check("post_rst_gnt_rr", {gnt1_r, gnt0_r}, 2'b01);
    check("post_rst_gnt_fp", {gnt1_f, gnt0_f}, 2'b01);
    step();
    check("post_rst_result", result_r, 16'h0011);
    check("post_rst_done", {done1_r, done0_r}, 2'b01);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single LC-3 ALU between two requesters: port 0 is the CPU datapath and port 1 is the auxiliary/debug engine.
- Arbitrates between them, registers the winner's opcode and operands, and drives them onto the ALU.
- Captures the ALU result and optionally updates an internal NZP condition-code register.
- Sits between the requesters and the ALU. It is the only driver of the ALU's ALUK/SR1/SR2 inputs.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- WIDTH, 16, datapath width for operands and result.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 requests an ALU operation.
- aluk0  in  2  port 0 opcode: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
- opa0  in  WIDTH  port 0 operand A (to SR1).
- opb0  in  WIDTH  port 0 operand B (to SR2).
- ldcc0  in  1  port 0 requests a CC update from this result.
- gnt0  out  1  one-cycle grant pulse to port 0.
- done0  out  1  one-cycle completion pulse to port 0.
- req1, aluk1, opa1, opb1, ldcc1, gnt1, done1: same as port 0, for port 1.
- alu_aluk  out  2  registered opcode to the ALU.
- alu_sr1  out  WIDTH  registered operand A to the ALU.
- alu_sr2  out  WIDTH  registered operand B to the ALU.
- alu_result  in  WIDTH  combinational ALU output.
- result  out  WIDTH  captured result; valid from the done pulse until the next capture.
- cc  out  3  NZP register {N,Z,P}.
- busy  out  1  high in EXEC and DONE.

Behaviour:
- Reset values (async, on Reset_n=0): state=IDLE, all gnt/done=0, busy=0, alu_aluk=00, alu_sr1=0, alu_sr2=0, result=0, cc=000, round-robin pointer favours port 0.
- States:
  - IDLE.
  - EXEC: ALU inputs stable, one cycle.
  - DONE: result registered, one cycle.
- Arbitration:
  - Happens on the clock edge leaving IDLE or DONE.
  - req0/req1 are sampled only in those states; a req raised and dropped during EXEC is never seen.
  - If any req is high, the winner's aluk/opa/opb are latched into alu_aluk/alu_sr1/alu_sr2, the winner's ldcc and identity are latched, and the next state is EXEC. Otherwise IDLE.
- Winner selection:
  - Only one req high: that port wins.
  - Both high, RR_EN=1: the port not granted most recently wins. The pointer updates on every grant.
  - Both high, RR_EN=0: port 0 wins.
- EXEC:
  - gnt of the winner is high for exactly this cycle.
  - alu_result is captured into result on the EXEC->DONE edge.
  - If the latched ldcc=1, cc is updated on the same edge: N=result[WIDTH-1]; Z=(result==0); P otherwise. Exactly one bit is set.
  - If ldcc=0, cc holds.
- DONE:
  - done of the winner is high for exactly this cycle.
  - result and cc are already updated and visible.
  - Arbitration occurs on exit, so a pending request goes straight to EXEC.
- Latency and throughput:
  - req sampled at edge T -> gnt during cycle T+1 -> done during cycle T+2, result valid from T+2.
  - Back-to-back throughput is one operation per 2 cycles.
- Requester rules:
  - opcode, operands and ldcc must be valid while req is high.
  - They may change after gnt, because operands are already latched.
  - A requester drops req the cycle after gnt unless it wants another operation. A req still high in DONE is treated as a new request.
- alu_aluk/alu_sr1/alu_sr2 hold their last values when IDLE and do not change during EXEC.
- At most one of gnt0/gnt1 is high at a time; the same holds for done0/done1.
- Reset mid-operation: abort immediately. No done pulse, result and cc return to reset values, pointer returns to port 0.
- All width arithmetic is performed by the ALU, so ADD wraps modulo 2^WIDTH. The arbiter only examines result for CC.

Test Plan:
1. Port 0 only, ADD 0x0003+0x0004, ldcc0=1 -> gnt0 one cycle after sampling, done0 the next cycle, result=0x0007, cc=001, gnt1/done1 stay 0.
2. Port 1 NOT of 0x0000 with ldcc1=1, then port 0 PASSA 0x1234 with ldcc0=0 -> result 0xFFFF with cc=100, then result 0x1234 with cc still 100.
3. RR_EN=1, req0 and req1 both held high from reset for 4 operations -> grant order 0,1,0,1, one done every 2 cycles, busy never drops between operations.
4. RR_EN=0, both req held high -> port 0 granted every time, and port 1 is granted only after req0 drops.
5. ADD 0x8000+0x8000 with ldcc=1 -> result=0x0000 and cc=010. AND 0xFFFF&0x00F0 -> result 0x00F0 and cc=001.
6. Reset_n pulsed low during EXEC -> no done pulse, result=0, cc=000, state=IDLE. A request immediately after reset is served, with port 0 winning a tie.
